// File: rtl/adc_scan_averager.sv
// Scans an ADC channel range, drops stale frames after each channel change,
// and emits one tagged average per channel. Optional macro: ADC_SCAN_ROUND_EN.
module adc_scan_averager #(
  parameter int CHAN_FIRST = 0,
  parameter int CHAN_LAST  = 7,
  parameter int LOG2_AVG   = 2,
  parameter int DISCARD    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        adc_convst,
  input  logic [11:0] adc_result,
  output logic [2:0]  chan,
  output logic [11:0] avg_data,
  output logic [2:0]  avg_chan,
  output logic        avg_valid
);

`ifdef ADC_SCAN_ROUND_EN
  // One guard bit keeps the half-LSB add from wrapping full-scale sums.
  localparam int GUARD = 1;
  localparam int RND   = (1 << LOG2_AVG) >> 1;
`else
  localparam int GUARD = 0;
  localparam int RND   = 0;
`endif

  localparam int ACC_W = 12 + LOG2_AVG + GUARD;
  localparam int CNT_W = LOG2_AVG + 1;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [3:0] DISC_INIT = 4'(DISCARD);
  localparam logic [2:0] CH_FIRST = 3'(CHAN_FIRST);
  localparam logic [2:0] CH_LAST  = 3'(CHAN_LAST);
  localparam logic [ACC_W-1:0] RND_V = ACC_W'(RND);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    ACCUM  = 2'd1,
    EMIT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             convst_q, convst_d;
  logic [2:0]       chan_q, chan_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       disc_q, disc_d;
  logic [11:0]      avg_data_q, avg_data_d;
  logic [2:0]       avg_chan_q, avg_chan_d;
  logic             avg_valid_q, avg_valid_d;

  logic             fr_edge;
  logic [ACC_W-1:0] acc_in;
  logic [ACC_W-1:0] acc_rnd;
  logic [2:0]       chan_inc;

  // Frame edge, running sums and the wrapped next channel.
  always_comb begin
    convst_d = adc_convst;
    fr_edge  = adc_convst & ~convst_q;
    acc_in   = acc_q + ACC_W'(adc_result);
    acc_rnd  = acc_in + RND_V;
    if (chan_q == CH_LAST) chan_inc = CH_FIRST;
    else                   chan_inc = chan_q + 3'd1;
  end

  // Settle / accumulate / emit sequencing; outputs are latched on the
  // final accumulated edge so they are visible during the EMIT cycle.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    disc_d      = disc_q;
    avg_data_d  = avg_data_q;
    avg_chan_d  = avg_chan_q;
    avg_valid_d = 1'b0;
    if (!enable) begin
      state_d = SETTLE;
      acc_d   = '0;
      cnt_d   = '0;
      disc_d  = DISC_INIT;
    end else begin
      unique case (state_q)
        SETTLE: begin
          if (fr_edge) begin
            disc_d = disc_q - 4'd1;
            if (disc_q == 4'd1) state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (fr_edge) begin
            if (cnt_q == CNT_LAST) begin
              avg_data_d  = 12'(acc_rnd >> LOG2_AVG);
              avg_chan_d  = chan_q;
              avg_valid_d = 1'b1;
              chan_d      = chan_inc;
              acc_d       = '0;
              cnt_d       = '0;
              disc_d      = DISC_INIT;
              state_d     = EMIT;
            end else begin
              acc_d = acc_in;
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        EMIT: begin
          state_d = SETTLE;
          if (fr_edge) begin
            disc_d = DISC_INIT - 4'd1;
            if (DISC_INIT == 4'd1) state_d = ACCUM;
          end
        end
        default: state_d = SETTLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SETTLE;
      convst_q    <= 1'b1;
      chan_q      <= CH_FIRST;
      acc_q       <= '0;
      cnt_q       <= '0;
      disc_q      <= DISC_INIT;
      avg_data_q  <= '0;
      avg_chan_q  <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      convst_q    <= convst_d;
      chan_q      <= chan_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      disc_q      <= disc_d;
      avg_data_q  <= avg_data_d;
      avg_chan_q  <= avg_chan_d;
      avg_valid_q <= avg_valid_d;
    end
  end

  assign chan      = chan_q;
  assign avg_data  = avg_data_q;
  assign avg_chan  = avg_chan_q;
  assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_adc_scan_averager.sv
// Randomized bench for adc_scan_averager with a frame-level reference model
// plus literal checks of the model on fixed sample patterns.
module tb_adc_scan_averager;

  localparam int D  = 2;
  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int CF = 0;
  localparam int CL = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        adc_convst = 1'b1;
  logic [11:0] adc_result = 12'h000;
  logic [2:0]  chan;
  logic [11:0] avg_data;
  logic [2:0]  avg_chan;
  logic        avg_valid;

  logic        enable1 = 1'b1;
  logic [11:0] full_scale = 12'hFFF;
  logic [2:0]  chan1;
  logic [11:0] avg_data1;
  logic [2:0]  avg_chan1;
  logic        avg_valid1;

  adc_scan_averager dut (
    .clk(clk), .reset(reset), .enable(enable),
    .adc_convst(adc_convst), .adc_result(adc_result),
    .chan(chan), .avg_data(avg_data),
    .avg_chan(avg_chan), .avg_valid(avg_valid)
  );

  adc_scan_averager #(
    .CHAN_FIRST(5), .CHAN_LAST(5), .LOG2_AVG(8), .DISCARD(2)
  ) dut_fs (
    .clk(clk), .reset(reset), .enable(enable1),
    .adc_convst(adc_convst), .adc_result(full_scale),
    .chan(chan1), .avg_data(avg_data1),
    .avg_chan(avg_chan1), .avg_valid(avg_valid1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: counts frame edges since the last restart.
  logic        m_prev = 1'b1;
  int          m_seen = 0;
  int          m_sum = 0;
  logic [2:0]  m_chan = 3'(CF);
  logic        m_valid = 1'b0;
  logic [11:0] m_data = '0;
  logic [2:0]  m_achan = '0;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      m_prev = 1'b1; m_seen = 0; m_sum = 0;
      m_chan = 3'(CF); m_valid = 1'b0;
      m_data = '0; m_achan = '0;
    end else begin
      logic e;
      m_valid = 1'b0;
      e = adc_convst && !m_prev;
      m_prev = adc_convst;
      if (!enable) begin
        m_seen = 0; m_sum = 0;
      end else if (e) begin
        m_seen++;
        if (m_seen > D) m_sum += int'(adc_result);
        if (m_seen == D + N) begin
`ifdef ADC_SCAN_ROUND_EN
          m_data = 12'((m_sum + N / 2) / N);
`else
          m_data = 12'(m_sum / N);
`endif
          m_achan = m_chan;
          m_valid = 1'b1;
          m_chan = (int'(m_chan) == CL) ? 3'(CF) : m_chan + 3'd1;
          m_seen = 0; m_sum = 0;
        end
      end
    end
  end

  int          valid_cnt = 0;
  int          fs_cnt = 0;
  logic [11:0] last_data = '0;
  logic [2:0]  last_achan = '0;
  logic [2:0]  chan_at_valid = '0;
  logic        tag_mode = 1'b0;

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("chan", 32'(chan), 32'(m_chan));
    check("avg_valid", 32'(avg_valid), 32'(m_valid));
    check("avg_data", 32'(avg_data), 32'(m_data));
    check("avg_chan", 32'(avg_chan), 32'(m_achan));
    check("fs_chan", 32'(chan1), 32'd5);
    if (avg_valid) begin
      valid_cnt++;
      last_data = avg_data;
      last_achan = avg_chan;
      chan_at_valid = chan;
      if (tag_mode)
        check("tag", 32'(avg_data[11:9]), 32'(avg_chan));
    end
    if (avg_valid1) begin
      fs_cnt++;
      check("fs_data", 32'(avg_data1), 32'hFFF);
      check("fs_achan", 32'(avg_chan1), 32'd5);
    end
  end

  logic [2:0] pipe_chan = '0;

  task automatic frame(input int lo, input int hi, input logic [11:0] v);
    for (int i = 0; i < lo; i++) begin
      adc_convst = 1'b0;
      @(posedge clk); #1;
    end
    adc_convst = 1'b1;
    adc_result = v;
    for (int i = 0; i < hi; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_chan", 32'(chan), 32'(CF));
    check("rst_valid", 32'(avg_valid), 32'd0);
    check("rst_data", 32'(avg_data), 32'd0);
    check("rst_achan", 32'(avg_chan), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int v0;
    logic [2:0] ch0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Constant 0x800: first average after edge D+N.
    v0 = valid_cnt;
    for (int k = 1; k <= 6; k++) begin
      frame(8, 8, 12'h800);
      if (k == 5) check("no_early_valid", 32'(valid_cnt), 32'(v0));
    end
    check("first_valid", 32'(valid_cnt), 32'(v0 + 1));
    check("first_data", 32'(last_data), 32'h800);
    check("first_achan", 32'(last_achan), 32'd0);
    check("first_chan_next", 32'(chan_at_valid), 32'd1);

    // Reset mid-accumulate, with nonzero outputs beforehand.
    for (int k = 0; k < 3; k++) frame(8, 8, 12'h123);
    do_reset();

    // Samples 1,2,3,4 after discards.
    v0 = valid_cnt;
    frame(8, 8, 12'd0);
    frame(8, 8, 12'd0);
    for (int k = 1; k <= 4; k++) frame(8, 8, 12'(k));
    check("avg_1234_cnt", 32'(valid_cnt), 32'(v0 + 1));
`ifdef ADC_SCAN_ROUND_EN
    check("avg_1234", 32'(last_data), 32'd3);
`else
    check("avg_1234", 32'(last_data), 32'd2);
`endif

    // Enable drop after two accumulated samples.
    for (int k = 0; k < D + 2; k++) frame(8, 8, 12'h100);
    ch0 = chan;
    v0 = valid_cnt;
    enable = 1'b0;
    for (int k = 0; k < 3; k++) frame(8, 8, 12'h100);
    check("en_low_novalid", 32'(valid_cnt), 32'(v0));
    check("en_low_chan", 32'(chan), 32'(ch0));
    enable = 1'b1;
    for (int k = 1; k <= D + 4; k++) begin
      frame(8, 8, 12'h200);
      if (k == D + 3) check("en_resettle", 32'(valid_cnt), 32'(v0));
    end
    check("en_emit", 32'(valid_cnt), 32'(v0 + 1));
    check("en_data", 32'(last_data), 32'h200);
    check("en_achan", 32'(last_achan), 32'(ch0));

    // Randomized frames with channel-tagged, one-frame-delayed results.
    tag_mode = 1'b1;
    pipe_chan = chan;
    v0 = valid_cnt;
    for (int k = 0; k < 600; k++) begin
      logic [11:0] v;
      if ($urandom_range(0, 39) == 0) enable = 1'b0;
      else enable = 1'b1;
      v = {pipe_chan, 9'($urandom)};
      frame($urandom_range(1, 6), $urandom_range(1, 6), v);
      pipe_chan = chan;
    end
    enable = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rand_emits", 32'(valid_cnt > v0 + 20), 32'd1);
    check("fs_emits", 32'(fs_cnt >= 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
